// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - request/response and ROM signals of the two-port instruction ROM arbiter
interface imem_arbiter_if;
    logic        req0;
    logic        req1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        rerr0;
    logic        rerr1;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport slave (
        input  req0, req1, addr0, addr1, mem_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rerr0, rerr1, mem_ce, mem_addr
    );

    modport master (
        output req0, req1, addr0, addr1, mem_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rerr0, rerr1, mem_ce, mem_addr
    );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin two-port arbiter in front of a combinational instruction ROM
module imem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int P0_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);
    // First byte address whose 4-byte word would not fit inside the ROM.
    localparam logic [31:0] LIMIT = 32'((64'd1 << ADDR_W) - 64'd3);

    logic        last;
    logic        rvalid0_q;
    logic        rvalid1_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;
    logic        rerr0_q;
    logic        rerr1_q;
    logic [15:0] wait_cnt0;
    logic [15:0] wait_cnt1;

    logic        sel1;
    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;
    logic        gerr;
    logic [31:0] gaddr;

    always_comb begin
        sel1    = bus.req1 && (!bus.req0 || !last);
        gnt0    = !rst && bus.req0 && !sel1;
        gnt1    = !rst && sel1;
        any_gnt = gnt0 || gnt1;
        gaddr   = gnt1 ? bus.addr1 : bus.addr0;
        gerr    = (gaddr[1:0] != 2'b00) || (gaddr >= LIMIT);
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.mem_ce   = any_gnt && !gerr;
    assign bus.mem_addr = (any_gnt && !gerr) ? gaddr : 32'd0;

    // A response still in flight when reset arrives is discarded, not presented.
    assign bus.rvalid0 = rvalid0_q && !rst;
    assign bus.rvalid1 = rvalid1_q && !rst;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rerr0   = rerr0_q;
    assign bus.rerr1   = rerr1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= (P0_FIRST != 0);
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
            rerr0_q   <= 1'b0;
            rerr1_q   <= 1'b0;
            wait_cnt0 <= 16'd0;
            wait_cnt1 <= 16'd0;
        end else begin
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            if (any_gnt) begin
                last <= gnt1;
            end
            if (gnt0) begin
                rdata0_q <= gerr ? 32'd0 : bus.mem_data;
                rerr0_q  <= gerr;
            end
            if (gnt1) begin
                rdata1_q <= gerr ? 32'd0 : bus.mem_data;
                rerr1_q  <= gerr;
            end

            if (gnt0) begin
                wait_cnt0 <= 16'd0;
            end else if (bus.req0 && wait_cnt0 != 16'hFFFF) begin
                wait_cnt0 <= wait_cnt0 + 16'd1;
            end
            if (gnt1) begin
                wait_cnt1 <= 16'd0;
            end else if (bus.req1 && wait_cnt1 != 16'hFFFF) begin
                wait_cnt1 <= wait_cnt1 + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [7:0] rom [0:2047];

    imem_arbiter_if bus ();

    imem_arbiter #(.ADDR_W(11), .P0_FIRST(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: bytes 0..3 = 78 56 34 12, every other byte equals its address mod 256.
    always_comb begin
        bus.mem_data = 32'hDEADBEEF;
        if (bus.mem_ce && bus.mem_addr <= 32'd2044) begin
            bus.mem_data = {rom[bus.mem_addr[10:0] + 11'd3], rom[bus.mem_addr[10:0] + 11'd2],
                            rom[bus.mem_addr[10:0] + 11'd1], rom[bus.mem_addr[10:0]]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b2b_exp [0:2];

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2048; i++) rom[i] = 8'(i);
        rom[0] = 8'h78; rom[1] = 8'h56; rom[2] = 8'h34; rom[3] = 8'h12;
        b2b_exp[0] = 32'h12345678;
        b2b_exp[1] = 32'h07060504;
        b2b_exp[2] = 32'h0B0A0908;

        // Reset: a request during rst is not accepted
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b0;
        bus.addr0 = 32'd0; bus.addr1 = 32'd0;
        cyc();
        check("rst_gnt0", 32'(bus.gnt0), 32'd0);
        check("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        cyc();
        check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        check("rst_rdata0", bus.rdata0, 32'd0);
        check("rst_rdata1", bus.rdata1, 32'd0);
        check("rst_wait0", 32'(dut.wait_cnt0), 32'd0);

        // Single fetch
        rst = 1'b0;
        #1;
        check("fetch_gnt0", 32'(bus.gnt0), 32'd1);
        check("fetch_gnt1", 32'(bus.gnt1), 32'd0);
        check("fetch_mem_ce", 32'(bus.mem_ce), 32'd1);
        check("fetch_mem_addr", bus.mem_addr, 32'd0);
        cyc();
        check("fetch_rvalid0", 32'(bus.rvalid0), 32'd1);
        check("fetch_rdata0", bus.rdata0, 32'h12345678);
        check("fetch_rerr0", 32'(bus.rerr0), 32'd0);
        check("fetch_rvalid1", 32'(bus.rvalid1), 32'd0);

        // Contention after a fresh reset: grants 0,1,0,1,0,1
        bus.req0 = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 32'd4; bus.addr1 = 32'd8;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("cont_gnt0", 32'(bus.gnt0), 32'((i % 2) == 0));
            check("cont_gnt1", 32'(bus.gnt1), 32'((i % 2) == 1));
            cyc();
            check("cont_rvalid0", 32'(bus.rvalid0), 32'((i % 2) == 0));
            check("cont_rvalid1", 32'(bus.rvalid1), 32'((i % 2) == 1));
            if ((i % 2) == 0) begin
                check("cont_rdata0", bus.rdata0, 32'h07060504);
                check("cont_wait1", 32'(dut.wait_cnt1), 32'd1);
                check("cont_wait0", 32'(dut.wait_cnt0), 32'd0);
            end else begin
                check("cont_rdata1", bus.rdata1, 32'h0B0A0908);
                check("cont_wait0", 32'(dut.wait_cnt0), 32'd1);
                check("cont_wait1", 32'(dut.wait_cnt1), 32'd0);
            end
        end

        // Back-to-back on port 0
        bus.req1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.addr0 = 32'(4 * i);
            #1;
            check("b2b_gnt0", 32'(bus.gnt0), 32'd1);
            cyc();
            check("b2b_rvalid0", 32'(bus.rvalid0), 32'd1);
            check("b2b_rdata0", bus.rdata0, b2b_exp[i]);
        end

        // Errors on port 1, then the last valid word
        bus.req0 = 1'b0; bus.req1 = 1'b1;
        bus.addr1 = 32'h2;
        #1;
        check("mis_gnt1", 32'(bus.gnt1), 32'd1);
        check("mis_mem_ce", 32'(bus.mem_ce), 32'd0);
        check("mis_mem_addr", bus.mem_addr, 32'd0);
        cyc();
        check("mis_rvalid1", 32'(bus.rvalid1), 32'd1);
        check("mis_rerr1", 32'(bus.rerr1), 32'd1);
        check("mis_rdata1", bus.rdata1, 32'd0);
        check("mis_rvalid0", 32'(bus.rvalid0), 32'd0);
        check("mis_rdata0_hold", bus.rdata0, 32'h0B0A0908);
        bus.addr1 = 32'h800;
        #1;
        check("oor_gnt1", 32'(bus.gnt1), 32'd1);
        check("oor_mem_ce", 32'(bus.mem_ce), 32'd0);
        cyc();
        check("oor_rvalid1", 32'(bus.rvalid1), 32'd1);
        check("oor_rerr1", 32'(bus.rerr1), 32'd1);
        check("oor_rdata1", bus.rdata1, 32'd0);
        bus.addr1 = 32'h1000_0000;
        #1;
        check("high_mem_ce", 32'(bus.mem_ce), 32'd0);
        cyc();
        check("high_rerr1", 32'(bus.rerr1), 32'd1);
        bus.addr1 = 32'h7FC;
        #1;
        check("edge_mem_ce", 32'(bus.mem_ce), 32'd1);
        check("edge_mem_addr", bus.mem_addr, 32'h7FC);
        cyc();
        check("edge_rvalid1", 32'(bus.rvalid1), 32'd1);
        check("edge_rerr1", 32'(bus.rerr1), 32'd0);
        check("edge_rdata1", bus.rdata1, 32'hFFFEFDFC);

        // Reset right after an accept discards the response
        bus.req1 = 1'b0; bus.req0 = 1'b1;
        bus.addr0 = 32'd0;
        #1;
        check("mid_gnt0", 32'(bus.gnt0), 32'd1);
        cyc();
        rst = 1'b1;
        bus.req0 = 1'b0;
        #1;
        check("mid_rvalid0_t1", 32'(bus.rvalid0), 32'd0);
        cyc();
        check("mid_rvalid0_t2", 32'(bus.rvalid0), 32'd0);
        rst = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 32'd0; bus.addr1 = 32'd4;
        #1;
        check("post_rst_gnt0", 32'(bus.gnt0), 32'd1);
        check("post_rst_gnt1", 32'(bus.gnt1), 32'd0);
        cyc();
        check("post_rst_rdata0", bus.rdata0, 32'h12345678);
        check("stall_wait1", 32'(dut.wait_cnt1), 32'd1);

        // Port 1 withdraws before being granted
        bus.req1 = 1'b0;
        bus.addr0 = 32'd4;
        #1;
        check("wd_gnt0", 32'(bus.gnt0), 32'd1);
        cyc();
        check("wd_rvalid1", 32'(bus.rvalid1), 32'd0);
        check("wd_rdata0", bus.rdata0, 32'h07060504);
        check("wd_wait1_hold", 32'(dut.wait_cnt1), 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b1;
        bus.addr1 = 32'd8;
        #1;
        check("wd_gnt1", 32'(bus.gnt1), 32'd1);
        cyc();
        check("wd_rvalid1_b", 32'(bus.rvalid1), 32'd1);
        check("wd_rdata1", bus.rdata1, 32'h0B0A0908);
        check("wd_wait1_clr", 32'(dut.wait_cnt1), 32'd0);

        // Idle
        bus.req1 = 1'b0;
        #1;
        check("idle_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
        check("idle_mem_ce", 32'(bus.mem_ce), 32'd0);
        check("idle_mem_addr", bus.mem_addr, 32'd0);
        cyc();
        check("idle_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
